// File: rtl/isa_pkg.sv
// ============================================================================
// Module      : isa_pkg
// Description : ISA constants, instruction field positions and the ID/EX
//               payload type shared by the decode/issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isa_pkg;

    localparam int REG_W   = 8;
    localparam int ADDR_W  = 3;
    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;
    localparam int IMM_W   = 8;

    // Instruction field positions (LSB of each field)
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
    localparam logic [OP_W-1:0] OP_AND  = 4'd3;
    localparam logic [OP_W-1:0] OP_OR   = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
    localparam logic [OP_W-1:0] OP_ADDI = 4'd6;
    localparam logic [OP_W-1:0] OP_LDI  = 4'd7;
    localparam logic [OP_W-1:0] OP_LD   = 4'd8;
    localparam logic [OP_W-1:0] OP_ST   = 4'd9;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  opa;
        logic [REG_W-1:0]  opb;
        logic [ADDR_W-1:0] destreg;
        logic              wen;
        logic              memrd;
        logic              memwr;
        logic              illegal;
        logic [REG_W-1:0]  store_data;
    } id_payload_t;

endpackage

`default_nettype wire

// File: rtl/decode_issue_stage_if.sv
// ============================================================================
// Module      : decode_issue_stage_if
// Description : Fetch-side and ID/EX-side valid/ready handshakes with payload.
//               slave = the decode stage, master = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decode_issue_stage_if;
    import isa_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  instr;

    logic                id_valid;
    logic                id_ready;
    logic [OP_W-1:0]     id_op;
    logic [REG_W-1:0]    id_opa;
    logic [REG_W-1:0]    id_opb;
    logic [ADDR_W-1:0]   id_destreg;
    logic                id_wen;
    logic                id_memrd;
    logic                id_memwr;
    logic                id_illegal;
    logic [REG_W-1:0]    id_store_data;

    modport slave (
        input  in_valid, instr, id_ready,
        output in_ready, id_valid, id_op, id_opa, id_opb, id_destreg,
               id_wen, id_memrd, id_memwr, id_illegal, id_store_data
    );

    modport master (
        output in_valid, instr, id_ready,
        input  in_ready, id_valid, id_op, id_opa, id_opb, id_destreg,
               id_wen, id_memrd, id_memwr, id_illegal, id_store_data
    );

endinterface

`default_nettype wire

// File: rtl/decode_issue_stage_fwd.sv
// ============================================================================
// Module      : operand_forward
// Description : Three-way operand source priority: EX result, WB data,
//               register-file read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_forward
    import isa_pkg::*;
(
    input  wire logic [ADDR_W-1:0] src_i,
    input  wire logic [REG_W-1:0]  rdata_i,
    input  wire logic              ex_wen_i,
    input  wire logic              ex_is_load_i,
    input  wire logic [ADDR_W-1:0] ex_destreg_i,
    input  wire logic [REG_W-1:0]  ex_result_i,
    input  wire logic              wb_write_i,
    input  wire logic [ADDR_W-1:0] wb_destreg_i,
    input  wire logic [REG_W-1:0]  wb_data_i,
    output logic      [REG_W-1:0]  data_o
);

    // A load in EX has no data yet, so it never forwards; the hazard unit
    // stalls instead. WB write-through covers the same-edge RF write.
    always_comb begin
        data_o = rdata_i;
        if (ex_wen_i && !ex_is_load_i && (ex_destreg_i == src_i)) begin
            data_o = ex_result_i;
        end else if (wb_write_i && (wb_destreg_i == src_i)) begin
            data_o = wb_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_issue_stage.sv
// ============================================================================
// Module      : decode_issue_stage
// Description : ID stage - decode, RF address generation, operand forwarding,
//               load-use hazard detection and the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_issue_stage
    import isa_pkg::*;
#(
    parameter int STALL_CNT_W = 16,
    parameter bit IMM_EN      = 1'b1
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    decode_issue_stage_if.slave         bus,
    output logic      [ADDR_W-1:0]      srcreg1,
    output logic      [ADDR_W-1:0]      srcreg2,
    input  wire logic [REG_W-1:0]       rdata1,
    input  wire logic [REG_W-1:0]       rdata2,
    input  wire logic                   ex_wen,
    input  wire logic                   ex_is_load,
    input  wire logic [ADDR_W-1:0]      ex_destreg,
    input  wire logic [REG_W-1:0]       ex_result,
    input  wire logic                   wb_write,
    input  wire logic [ADDR_W-1:0]      wb_destreg,
    input  wire logic [REG_W-1:0]       wb_data,
    input  wire logic                   flush,
    output logic      [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] rd, rs1, rs2;
    logic [IMM_W-1:0]  imm;
    logic [REG_W-1:0]  fwd1, fwd2;
    logic              use1, use2;
    logic              hazard, adv, in_ready_w, accept;
    id_payload_t       dec_d, payload_q;
    logic              valid_q;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    assign opcode  = bus.instr[OPC_LSB +: OP_W];
    assign rd      = bus.instr[RD_LSB  +: ADDR_W];
    assign rs1     = bus.instr[RS1_LSB +: ADDR_W];
    assign rs2     = bus.instr[RS2_LSB +: ADDR_W];
    assign imm     = bus.instr[IMM_LSB +: IMM_W];

    // ADDI reads its own destination as the first operand
    assign srcreg1 = (opcode == OP_ADDI) ? rd : rs1;
    assign srcreg2 = rs2;

    operand_forward u_fwd1 (
        .src_i(srcreg1), .rdata_i(rdata1),
        .ex_wen_i(ex_wen), .ex_is_load_i(ex_is_load),
        .ex_destreg_i(ex_destreg), .ex_result_i(ex_result),
        .wb_write_i(wb_write), .wb_destreg_i(wb_destreg), .wb_data_i(wb_data),
        .data_o(fwd1)
    );

    operand_forward u_fwd2 (
        .src_i(srcreg2), .rdata_i(rdata2),
        .ex_wen_i(ex_wen), .ex_is_load_i(ex_is_load),
        .ex_destreg_i(ex_destreg), .ex_result_i(ex_result),
        .wb_write_i(wb_write), .wb_destreg_i(wb_destreg), .wb_data_i(wb_data),
        .data_o(fwd2)
    );

    // Instruction decode into the ID/EX payload and source-use flags
    always_comb begin
        dec_d         = '0;
        dec_d.op      = opcode;
        dec_d.destreg = rd;
        use1          = 1'b0;
        use2          = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                use1      = 1'b1;
                use2      = 1'b1;
                dec_d.opa = fwd1;
                dec_d.opb = fwd2;
                dec_d.wen = 1'b1;
            end
            OP_ADDI: begin
                if (IMM_EN) begin
                    use1      = 1'b1;
                    dec_d.opa = fwd1;
                    dec_d.opb = imm;
                    dec_d.wen = 1'b1;
                end else begin
                    dec_d.illegal = 1'b1;
                end
            end
            OP_LDI: begin
                if (IMM_EN) begin
                    dec_d.opb = imm;
                    dec_d.wen = 1'b1;
                end else begin
                    dec_d.illegal = 1'b1;
                end
            end
            OP_LD: begin
                use1        = 1'b1;
                dec_d.opa   = fwd1;
                dec_d.memrd = 1'b1;
                dec_d.wen   = 1'b1;
            end
            OP_ST: begin
                use1             = 1'b1;
                use2             = 1'b1;
                dec_d.opa        = fwd1;
                dec_d.store_data = fwd2;
                dec_d.memwr      = 1'b1;
            end
            default: dec_d.illegal = 1'b1;
        endcase
    end

    assign hazard     = bus.in_valid && ex_wen && ex_is_load &&
                        ((use1 && (ex_destreg == srcreg1)) ||
                         (use2 && (ex_destreg == srcreg2)));
    assign adv        = !valid_q || bus.id_ready;
    // Gated by reset so fetch sees no acceptance while the stage is held
    assign in_ready_w = reset && adv && !hazard && !flush;
    assign accept     = bus.in_valid && in_ready_w;
    assign stall_d    = (hazard && !flush && (stall_q != CNT_MAX)) ? (stall_q + CNT_ONE) : stall_q;

    // ID/EX pipeline register: flush kills, otherwise load on advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (flush) begin
            valid_q   <= 1'b0;
        end else if (adv) begin
            valid_q   <= accept;
            if (accept) begin
                payload_q <= dec_d;
            end
        end
    end

    // Saturating load-use stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count       = stall_q;
    assign bus.in_ready      = in_ready_w;
    assign bus.id_valid      = valid_q;
    assign bus.id_op         = payload_q.op;
    assign bus.id_opa        = payload_q.opa;
    assign bus.id_opb        = payload_q.opb;
    assign bus.id_destreg    = payload_q.destreg;
    assign bus.id_wen        = payload_q.wen;
    assign bus.id_memrd      = payload_q.memrd;
    assign bus.id_memwr      = payload_q.memwr;
    assign bus.id_illegal    = payload_q.illegal;
    assign bus.id_store_data = payload_q.store_data;

endmodule

`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
// ============================================================================
// Module      : tb_decode_issue_stage
// Description : Directed self-checking bench for decode_issue_stage.
//               Register file returns R[i] = i. A second instance with a
//               2-bit stall counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_issue_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] srcreg1, srcreg2, srcreg1b, srcreg2b;
    logic [7:0] rdata1, rdata2, rdata1b, rdata2b;
    logic       ex_wen, ex_is_load, wb_write, flush;
    logic [2:0] ex_destreg, wb_destreg;
    logic [7:0] ex_result, wb_data;
    logic [15:0] stall_count;
    logic [1:0]  stall_count2;

    int checks   = 0;
    int failures = 0;

    decode_issue_stage_if bus ();
    decode_issue_stage_if bus2 ();

    always #5 clk = ~clk;

    // Register file model: register i holds value i
    assign rdata1  = {5'b0, srcreg1};
    assign rdata2  = {5'b0, srcreg2};
    assign rdata1b = {5'b0, srcreg1b};
    assign rdata2b = {5'b0, srcreg2b};

    assign bus2.in_valid = bus.in_valid;
    assign bus2.instr    = bus.instr;
    assign bus2.id_ready = bus.id_ready;

    decode_issue_stage dut (
        .clk(clk), .reset(reset), .bus(bus),
        .srcreg1(srcreg1), .srcreg2(srcreg2),
        .rdata1(rdata1), .rdata2(rdata2),
        .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .ex_destreg(ex_destreg), .ex_result(ex_result),
        .wb_write(wb_write), .wb_destreg(wb_destreg), .wb_data(wb_data),
        .flush(flush), .stall_count(stall_count)
    );

    decode_issue_stage #(.STALL_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .srcreg1(srcreg1b), .srcreg2(srcreg2b),
        .rdata1(rdata1b), .rdata2(rdata2b),
        .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .ex_destreg(ex_destreg), .ex_result(ex_result),
        .wb_write(wb_write), .wb_destreg(wb_destreg), .wb_data(wb_data),
        .flush(flush), .stall_count(stall_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.instr    = 16'h1650;
        bus.id_ready = 1'b1;
        ex_wen = 1'b0; ex_is_load = 1'b0; ex_destreg = 3'd0; ex_result = 8'h00;
        wb_write = 1'b0; wb_destreg = 3'd0; wb_data = 8'h00;
        flush = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_id_valid", bus.id_valid, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_id_op", bus.id_op, 0);
        chk("rst_id_wen", bus.id_wen, 0);
        reset = 1'b1;
        #1;

        // ADD r3,r1,r2
        chk("add_in_ready", bus.in_ready, 1);
        chk("add_srcreg1", srcreg1, 1);
        chk("add_srcreg2", srcreg2, 2);
        tick();
        chk("add_valid", bus.id_valid, 1);
        chk("add_op", bus.id_op, 1);
        chk("add_opa", bus.id_opa, 1);
        chk("add_opb", bus.id_opb, 2);
        chk("add_dest", bus.id_destreg, 3);
        chk("add_wen", bus.id_wen, 1);

        // ADD r4,r3,r1 : EX beats WB on r3
        bus.instr = 16'h18C8;
        ex_wen = 1'b1; ex_destreg = 3'd3; ex_result = 8'h33;
        wb_write = 1'b1; wb_destreg = 3'd3; wb_data = 8'h55;
        tick();
        chk("exfwd_opa", bus.id_opa, 8'h33);
        chk("exfwd_opb", bus.id_opb, 1);
        chk("exfwd_dest", bus.id_destreg, 4);
        // WB only
        ex_wen = 1'b0;
        tick();
        chk("wbfwd_opa", bus.id_opa, 8'h55);
        wb_write = 1'b0;

        // Load-use on SUB r5,r2,r1
        bus.instr = 16'h2A88;
        ex_wen = 1'b1; ex_is_load = 1'b1; ex_destreg = 3'd2;
        #1;
        chk("lu_in_ready", bus.in_ready, 0);
        tick();
        chk("lu_bubble", bus.id_valid, 0);
        chk("lu_stall", stall_count, 1);
        ex_wen = 1'b0; ex_is_load = 1'b0;
        #1;
        chk("lu_release_ready", bus.in_ready, 1);
        tick();
        chk("lu_valid", bus.id_valid, 1);
        chk("lu_op", bus.id_op, 2);
        chk("lu_opa", bus.id_opa, 2);
        chk("lu_opb", bus.id_opb, 1);
        chk("lu_dest", bus.id_destreg, 5);

        // Immediate and memory ops
        bus.instr = 16'h6A14;   // ADDI r5, 0x14
        #1;
        chk("addi_srcreg1", srcreg1, 5);
        tick();
        chk("addi_opa", bus.id_opa, 5);
        chk("addi_opb", bus.id_opb, 8'h14);
        chk("addi_wen", bus.id_wen, 1);
        bus.instr = 16'h7E80;   // LDI r7, 0x80
        tick();
        chk("ldi_opa", bus.id_opa, 0);
        chk("ldi_opb", bus.id_opb, 8'h80);
        chk("ldi_dest", bus.id_destreg, 7);
        bus.instr = 16'h84C0;   // LD r2, [r3]
        tick();
        chk("ld_opa", bus.id_opa, 3);
        chk("ld_memrd", bus.id_memrd, 1);
        chk("ld_wen", bus.id_wen, 1);
        bus.instr = 16'h9098;   // ST [r2], r3
        tick();
        chk("st_opa", bus.id_opa, 2);
        chk("st_data", bus.id_store_data, 3);
        chk("st_memwr", bus.id_memwr, 1);
        chk("st_wen", bus.id_wen, 0);
        bus.instr = 16'h0000;   // NOP
        tick();
        chk("nop_valid", bus.id_valid, 1);
        chk("nop_op", bus.id_op, 0);
        chk("nop_wen", bus.id_wen, 0);
        chk("nop_memwr", bus.id_memwr, 0);

        // Backpressure: XOR r6,r1,r2 held while OR r7,r2,r3 waits
        bus.instr = 16'h5C50;
        tick();
        bus.id_ready = 1'b0;
        bus.instr    = 16'h4E98;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", bus.in_ready, 0);
            tick();
            chk("bp_valid", bus.id_valid, 1);
            chk("bp_op", bus.id_op, 5);
            chk("bp_opa", bus.id_opa, 1);
            chk("bp_opb", bus.id_opb, 2);
            chk("bp_dest", bus.id_destreg, 6);
        end
        bus.id_ready = 1'b1;
        #1;
        chk("bp_release_ready", bus.in_ready, 1);
        tick();
        chk("bp_next_valid", bus.id_valid, 1);
        chk("bp_next_op", bus.id_op, 4);
        chk("bp_next_opa", bus.id_opa, 2);
        chk("bp_next_opb", bus.id_opb, 3);
        chk("bp_next_dest", bus.id_destreg, 7);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_issued_once", bus.id_valid, 0);

        // Flush during a stall with id_ready low
        bus.in_valid = 1'b1;
        bus.instr    = 16'h1650;
        tick();
        chk("fl_pre_valid", bus.id_valid, 1);
        bus.id_ready = 1'b0;
        ex_wen = 1'b1; ex_is_load = 1'b1; ex_destreg = 3'd1;
        flush = 1'b1;
        #1;
        chk("fl_in_ready", bus.in_ready, 0);
        tick();
        chk("fl_valid", bus.id_valid, 0);
        chk("fl_stall_unchanged", stall_count, 1);
        flush = 1'b0;
        ex_wen = 1'b0; ex_is_load = 1'b0;
        bus.id_ready = 1'b1;
        bus.instr    = 16'hF000;
        tick();
        chk("ill_valid", bus.id_valid, 1);
        chk("ill_flag", bus.id_illegal, 1);
        chk("ill_wen", bus.id_wen, 0);

        // Asynchronous reset mid-cycle
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", bus.id_valid, 0);
        chk("arst_stall", stall_count, 0);
        chk("arst_illegal", bus.id_illegal, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        #1;
        reset = 1'b1;

        // Saturation: 16-bit counter keeps counting, 2-bit one sticks at 3
        bus.in_valid = 1'b1;
        bus.instr    = 16'h2A88;
        ex_wen = 1'b1; ex_is_load = 1'b1; ex_destreg = 3'd2;
        repeat (3) tick();
        chk("sat_cnt16_3", stall_count, 3);
        chk("sat_cnt2_3", stall_count2, 3);
        repeat (2) tick();
        chk("sat_cnt16_5", stall_count, 5);
        chk("sat_cnt2_hold", stall_count2, 3);
        chk("sat_no_issue", bus.id_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
